instr_field_decode: RTL

INSTR_FIELD_DECODE -- requirements
Module: instr_field_decode

---
 rtl/instr_field_decode.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/instr_field_decode.sv
// Instruction register with a fetch/decode handshake FSM.
// Captures a word from memory, splits it into RV32I fields and holds them until acked.
module instr_field_decode (
    input  logic        clk,
    input  logic        rst,
    input  logic        ir_load,
    input  logic [31:0] mem_rdata,
    input  logic        mem_valid,
    input  logic        ack,
    output logic [31:0] instr,
    output logic [6:0]  opcode,
    output logic [4:0]  rd,
    output logic [2:0]  funct3,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [6:0]  funct7,
    output logic [11:0] imm12,
    output logic [19:0] imm20,
    output logic [2:0]  imm_type,
    output logic        dec_valid,
    output logic        illegal,
    output logic        fetch_err,
    output logic        busy
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_WAIT   = 2'd1;
    localparam logic [1:0] S_DECODE = 2'd2;
    localparam logic [1:0] S_VALID  = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] instr_q, instr_d;
    logic [6:0]  opcode_q, opcode_d;
    logic [4:0]  rd_q, rd_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [4:0]  rs1_q, rs1_d;
    logic [4:0]  rs2_q, rs2_d;
    logic [6:0]  funct7_q, funct7_d;
    logic [11:0] imm12_q, imm12_d;
    logic [19:0] imm20_q, imm20_d;
    logic [2:0]  imm_type_q, imm_type_d;
    logic        illegal_q, illegal_d;
    logic        dec_valid_q, dec_valid_d;
    logic        fetch_err_q, fetch_err_d;
    logic        busy_q, busy_d;

    logic [11:0] dec_imm12;
    logic [19:0] dec_imm20;
    logic [2:0]  dec_type;
    logic        dec_illegal;

    // Immediate extraction from the held instruction word
    always_comb begin
        dec_imm12   = '0;
        dec_imm20   = '0;
        dec_type    = 3'd0;
        dec_illegal = 1'b0;
        unique case (instr_q[6:0])
            7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: begin
                dec_type  = 3'd1;
                dec_imm12 = instr_q[31:20];
            end
            7'b0100011: begin
                dec_type  = 3'd2;
                dec_imm12 = {instr_q[31:25], instr_q[11:7]};
            end
            7'b1100011: begin
                dec_type  = 3'd3;
                dec_imm12 = {instr_q[31], instr_q[7],
                             instr_q[30:25], instr_q[11:8]};
            end
            7'b0110111, 7'b0010111: begin
                dec_type  = 3'd4;
                dec_imm20 = instr_q[31:12];
            end
            7'b1101111: begin
                dec_type  = 3'd5;
                dec_imm20 = {instr_q[31], instr_q[19:12],
                             instr_q[20], instr_q[30:21]};
            end
            7'b0110011: begin
                dec_type  = 3'd0;
            end
            default: begin
                dec_type    = 3'd7;
                dec_illegal = 1'b1;
            end
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        instr_d     = instr_q;
        opcode_d    = opcode_q;
        rd_d        = rd_q;
        funct3_d    = funct3_q;
        rs1_d       = rs1_q;
        rs2_d       = rs2_q;
        funct7_d    = funct7_q;
        imm12_d     = imm12_q;
        imm20_d     = imm20_q;
        imm_type_d  = imm_type_q;
        illegal_d   = illegal_q;
        fetch_err_d = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (ir_load) begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
                end
            end
            S_WAIT: begin
                // A late word on the final wait cycle still wins over the timeout
                if (mem_valid) begin
                    instr_d = mem_rdata;
                    state_d = S_DECODE;
                end else if (cnt_q == 4'd15) begin
                    state_d     = S_IDLE;
                    fetch_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_DECODE: begin
                opcode_d   = instr_q[6:0];
                rd_d       = instr_q[11:7];
                funct3_d   = instr_q[14:12];
                rs1_d      = instr_q[19:15];
                rs2_d      = instr_q[24:20];
                funct7_d   = instr_q[31:25];
                imm12_d    = dec_imm12;
                imm20_d    = dec_imm20;
                imm_type_d = dec_type;
                illegal_d  = dec_illegal;
                state_d    = S_VALID;
            end
            S_VALID: begin
                if (ack) begin
                    state_d = ir_load ? S_WAIT : S_IDLE;
                    cnt_d   = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d      = (state_d != S_IDLE);
        dec_valid_d = (state_d == S_VALID);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            instr_q     <= '0;
            opcode_q    <= '0;
            rd_q        <= '0;
            funct3_q    <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            funct7_q    <= '0;
            imm12_q     <= '0;
            imm20_q     <= '0;
            imm_type_q  <= '0;
            illegal_q   <= 1'b0;
            dec_valid_q <= 1'b0;
            fetch_err_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            instr_q     <= instr_d;
            opcode_q    <= opcode_d;
            rd_q        <= rd_d;
            funct3_q    <= funct3_d;
            rs1_q       <= rs1_d;
            rs2_q       <= rs2_d;
            funct7_q    <= funct7_d;
            imm12_q     <= imm12_d;
            imm20_q     <= imm20_d;
            imm_type_q  <= imm_type_d;
            illegal_q   <= illegal_d;
            dec_valid_q <= dec_valid_d;
            fetch_err_q <= fetch_err_d;
            busy_q      <= busy_d;
        end
    end

    assign instr     = instr_q;
    assign opcode    = opcode_q;
    assign rd        = rd_q;
    assign funct3    = funct3_q;
    assign rs1       = rs1_q;
    assign rs2       = rs2_q;
    assign funct7    = funct7_q;
    assign imm12     = imm12_q;
    assign imm20     = imm20_q;
    assign imm_type  = imm_type_q;
    assign illegal   = illegal_q;
    assign dec_valid = dec_valid_q;
    assign fetch_err = fetch_err_q;
    assign busy      = busy_q;

endmodule
